// File: rtl/waveform_recorder.sv
// ---------------------------------------------------------------------------
// waveform_recorder
//
// Captures a multi-channel sample stream into an on-chip circular buffer at a
// programmable sample rate. Once armed, it freezes a DEPTH-row window around a
// trigger, keeping PRE rows from before the trigger. The frozen window is then
// drained oldest-first over a valid/ready stream.
//
// Parameters
//   BITS      bits per channel sample
//   CHANNELS  channels per row, channel j at [BITS*j +: BITS]
//   DEPTH     rows per capture window (power of two, >= 4)
//   DIVIDE    clock cycles per sample tick (>= 1)
//   PRE       pre-trigger rows (0 <= PRE < DEPTH)
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous active-low reset (control state only)
//   data       sampled input row
//   arm        start a capture, honoured in IDLE only
//   trigger    trigger level, looked at on tick cycles in WAIT only
//   abort      return to IDLE; beats everything except reset
//   out_data   drained row
//   out_valid  out_data is valid
//   out_ready  consumer accepts the row
//   out_last   final row of the window, qualified by out_valid
//   busy       recorder is not IDLE
//   state      IDLE=0, FILL=1, WAIT=2, CAPTURE=3, DRAIN=4
// ---------------------------------------------------------------------------
module waveform_recorder #(
  parameter int BITS     = 16,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 64,
  parameter int DIVIDE   = 15625,
  parameter int PRE      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BITS*CHANNELS-1:0] data,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic                     abort,
  output logic [BITS*CHANNELS-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic [2:0]               state
);

  localparam int W  = BITS * CHANNELS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIVIDE - 1);
  localparam logic [CW-1:0] PRE_ROWS   = CW'(PRE);
  localparam logic [CW-1:0] POST_ROWS  = CW'(DEPTH - PRE);
  localparam logic [CW-1:0] DEPTH_ROWS = CW'(DEPTH);
  localparam logic [AW-1:0] PRE_OFFSET = AW'(PRE);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] divCnt_q, divCnt_d;
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] startPtr_q, startPtr_d;
  // Row counter shared by the phases: pre-trigger rows written in FILL,
  // post-trigger rows written in CAPTURE, rows issued to the output in DRAIN.
  logic [CW-1:0] rowCnt_q, rowCnt_d;
  logic [W-1:0]  outData_q, outData_d;
  logic          outValid_q, outValid_d;
  logic          outLast_q, outLast_d;

  logic [W-1:0]  mem [DEPTH];

  logic          sampling;
  logic          tick;
  logic          xfer;
  logic          memWrite;

  assign sampling = (state_q == FILL) || (state_q == WAIT) || (state_q == CAPTURE);
  assign tick     = sampling && (divCnt_q == DIV_LAST);
  assign xfer     = outValid_q && out_ready;
  assign memWrite = tick && rst_n && !abort;

  // Next-state and datapath decisions for the capture/drain sequence.
  always_comb begin
    state_d    = state_q;
    divCnt_d   = divCnt_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    startPtr_d = startPtr_q;
    rowCnt_d   = rowCnt_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;

    if (sampling) begin
      divCnt_d = tick ? '0 : divCnt_q + 1'b1;
    end
    if (tick) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        divCnt_d   = '0;
        wrPtr_d    = '0;
        rdPtr_d    = '0;
        startPtr_d = '0;
        rowCnt_d   = '0;
        if (arm) begin
          state_d = (PRE > 0) ? FILL : WAIT;
        end
      end

      FILL: begin
        if (tick) begin
          if (rowCnt_q == PRE_ROWS - 1'b1) begin
            state_d  = WAIT;
            rowCnt_d = '0;
          end else begin
            rowCnt_d = rowCnt_q + 1'b1;
          end
        end
      end

      WAIT: begin
        if (tick && trigger) begin
          // The trigger sample itself is post-trigger row 1; the window
          // starts PRE rows behind it in the ring.
          startPtr_d = wrPtr_q - PRE_OFFSET;
          if (POST_ROWS == CW'(1)) begin
            state_d  = DRAIN;
            rdPtr_d  = wrPtr_q - PRE_OFFSET;
            rowCnt_d = '0;
          end else begin
            state_d  = CAPTURE;
            rowCnt_d = CW'(1);
          end
        end
      end

      CAPTURE: begin
        if (tick) begin
          if (rowCnt_q == POST_ROWS - 1'b1) begin
            state_d  = DRAIN;
            rdPtr_d  = startPtr_q;
            rowCnt_d = '0;
          end else begin
            rowCnt_d = rowCnt_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        divCnt_d = '0;
        // The output register is refilled whenever it is empty or its row is
        // leaving this cycle, which gives one row per cycle under constant
        // out_ready and holds the row steady while the consumer stalls.
        if (xfer && outLast_q) begin
          state_d    = IDLE;
          outValid_d = 1'b0;
          outLast_d  = 1'b0;
        end else if ((!outValid_q || xfer) && (rowCnt_q != DEPTH_ROWS)) begin
          outData_d  = mem[rdPtr_q];
          outValid_d = 1'b1;
          outLast_d  = (rowCnt_q == DEPTH_ROWS - 1'b1);
          rdPtr_d    = rdPtr_q + 1'b1;
          rowCnt_d   = rowCnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d    = IDLE;
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end
  end

  // Control and output registers; only these are cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      divCnt_q   <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      startPtr_q <= '0;
      rowCnt_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      startPtr_q <= startPtr_d;
      rowCnt_q   <= rowCnt_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
    end
  end

  // Sample buffer; deliberately not reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem[wrPtr_q] <= data;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign out_last  = outLast_q;
  assign busy      = (state_q != IDLE);
  assign state     = state_q;

endmodule

// File: doc/waveform_recorder.md
# waveform_recorder

Synthesisable, clocked successor to the simulation-only waveform dump: captures a multi-channel sample stream at a programmable sample rate into an on-chip circular buffer, arms on command, and freezes a window around a trigger with a configurable pre-trigger depth. The captured window is drained row by row over a valid/ready stream to a UART, file-writer or debug port. It sits beside the signal path, observing `data` without loading it.

## Interface
- `BITS`, 16, bits per channel sample
- `CHANNELS`, 1, channels per row; channel j at `[BITS*j +: BITS]`
- `DEPTH`, 64, rows per capture window; power of two, ≥ 4
- `DIVIDE`, 15625, clock cycles per sample tick (100 MHz / 6400 Hz); ≥ 1
- `PRE`, 0, pre-trigger rows; 0 ≤ PRE < DEPTH

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `data`  in  BITS*CHANNELS  sampled input row
- `arm`  in  1  start capture (honoured in IDLE only)
- `trigger`  in  1  trigger level, checked on tick cycles in WAIT only
- `abort`  in  1  return to IDLE, highest priority after reset
- `out_data`  out  BITS*CHANNELS  drained row
- `out_valid`  out  1  out_data valid
- `out_ready`  in  1  consumer accepts row
- `out_last`  out  1  final row of window, qualified by out_valid
- `busy`  out  1  state ≠ IDLE
- `state`  out  3  IDLE=0, FILL=1, WAIT=2, CAPTURE=3, DRAIN=4

## Operation
- Tick: divider counts 0..DIVIDE-1 in FILL/WAIT/CAPTURE; tick when count = DIVIDE-1, then wraps to 0. Counter cleared on arm. DIVIDE=1 ticks every cycle. On a tick, `data` is written to mem[wr_ptr] and wr_ptr increments mod DEPTH.
- IDLE: wr_ptr, counters cleared. arm → FILL if PRE > 0, else WAIT.
- FILL: writes PRE ticks; after PRE-th write → WAIT. trigger ignored.
- WAIT: writes every tick, buffer wraps freely. Tick with trigger=1: that sample is written as post-trigger row 1; start_ptr = (its address − PRE) mod DEPTH; → CAPTURE (or DRAIN if DEPTH−PRE = 1).
- CAPTURE: writes until DEPTH−PRE post-trigger rows stored, → DRAIN, rd_ptr = start_ptr.
- DRAIN: presents DEPTH rows in capture order (oldest pre-trigger first). Transfer on out_valid & out_ready; rd_ptr increments mod DEPTH. out_last high on row DEPTH. Transfer of last row → IDLE.
- abort in any state → IDLE next edge; out_valid, out_last drop; memory not cleared. arm/trigger outside their states ignored. arm and abort together: abort wins.
- Memory is not reset; only control state is.

## Timing
- Reset (rst_n low at an edge): state=0, busy=0, out_valid=0, out_last=0, out_data=0, all pointers/counters 0.
- First sample tick DIVIDE cycles after the arm edge; `data` sampled on the tick-cycle edge.
- State changes on the edge of the deciding tick/transfer; busy follows state same cycle.
- DRAIN: out_valid rises one cycle after entering DRAIN (registered memory read). Zero-bubble streaming when out_ready held high: one row per cycle.
- While out_valid & !out_ready: out_data, out_last held stable.
- out_valid falls the cycle after the last transfer.

## Test plan
Params DEPTH=8, PRE=2, DIVIDE=4, CHANNELS=2, BITS=16; ch0 = tick index k, ch1 = k+0x100.
- Reset: rst_n low 2 cycles mid-DRAIN → state=0, busy=0, out_valid=0, out_data=0 after first low edge.
- Pre-trigger wrap: arm, trigger high only at tick 10 → rows ch0 = 8,9,10..15, ch1 = 0x108..0x10F; out_last on row 8 only; state returns 0.
- Backpressure: same capture, out_ready toggles 1,0,0,1,… → each row exactly once, out_data/out_last stable during stalls, order unchanged.
- Trigger during FILL: trigger held high from arm → fires at tick 2; rows 0..7.
- PRE=0: trigger high at first tick → rows 0..7, out_valid one cycle after state=4.
- Abort: abort during CAPTURE → state=0 next edge, busy=0, no out_valid; re-arm with trigger at tick 10 → rows 8..15.
